switch_debounce_ctrl: RTL and testbench
=======================================

// Module: switch_debounce_ctrl
// PURPOSE
//  Upstream conditioning stage for the Go-board switch inputs: synchronises raw
//  mechanical switch levels to i_Clk and debounces them. Produces clean levels,
//  single-cycle press/release pulses and an optional press-toggled level.
//  Its outputs drive the enable/reset inputs of the switch-controlled LED counter.
//  NUM_SW independent channels share one clock and one reset.
// PARAMETERS
//  NUM_SW          2        number of switch channels (>=1)
//  DEBOUNCE_LIMIT  250000   consecutive stable cycles required (10 ms @ 25 MHz); >=2
// PORTS
//  i_Clk       in   1       system clock, 25 MHz
//  i_Rst_L     in   1       reset; asynchronous assert, active-low
//  i_Switch    in   NUM_SW  raw asynchronous switch levels, 1 = pressed
//  o_Switch    out  NUM_SW  debounced level
//  o_Press     out  NUM_SW  1-cycle pulse on debounced 0->1
//  o_Release   out  NUM_SW  1-cycle pulse on debounced 1->0
//  o_Toggle    out  NUM_SW  level inverted on every press (feature-gated)
// BEHAVIOUR
//  - Reset (i_Rst_L=0): all outputs 0, sync flops 0, counters 0,
//    FSM=STABLE_LO, immediately, independent of i_Clk.
//  - Sync: 2-flop synchroniser per channel; s = 2nd-stage output.
//  - Per-channel FSM: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
//    STABLE_LO: s=1 -> PEND_HI, cnt=1.        STABLE_HI: s=0 -> PEND_LO, cnt=1.
//    PEND_HI: s=0 -> STABLE_LO, cnt=0 (glitch rejected).
//             s=1, cnt<DEBOUNCE_LIMIT -> cnt+1.
//             s=1, cnt==DEBOUNCE_LIMIT -> STABLE_HI, o_Switch<=1, o_Press<=1.
//    PEND_LO: mirror of PEND_HI; exit sets o_Switch<=0, o_Release<=1.
//  - Latency: raw level first sampled at edge N -> o_Switch changes at edge
//    N+2+DEBOUNCE_LIMIT, exactly. Press/Release assert on that same edge, for
//    one cycle only.
//  - Any opposite sample during PEND_* restarts the full window. A disturbance
//    shorter than DEBOUNCE_LIMIT cycles produces no output change.
//  - Counter width $clog2(DEBOUNCE_LIMIT+1). It saturates by construction and
//    never wraps.
//  - Channels are fully independent; simultaneous events on different channels
//    are all reported in the same cycle. Press and Release never coincide on
//    one channel.
//  - Reset mid-PEND: pending count discarded and no pulse emitted. After
//    release, a raw level still held high is re-debounced over the full
//    latency and yields a fresh Press.
// CONFIGURATION
//  SWITCH_DEBOUNCE_TOGGLE_EN defined: per-channel toggle flop, reset 0,
//    inverts on the edge where o_Press asserts (o_Toggle updates with o_Press).
//  Not defined: toggle flop not built; o_Toggle tied to constant 0.
// TESTING  (NUM_SW=2, DEBOUNCE_LIMIT=8, 40 ns clock, macro defined unless noted)
//  1. i_Rst_L=0, i_Switch=2'b11 for 20 cycles -> all outputs 2'b00 throughout.
//  2. i_Switch[0] 0->1 sampled at edge N, held -> o_Switch[0]=1 at edge N+10;
//     o_Press[0]=1 for exactly that cycle; o_Toggle[0]=1; channel 1 stays 0.
//  3. i_Switch[0] bounces (3 hi / 2 lo) x5, then held 1 -> exactly one
//     o_Press[0] pulse, 10 edges after the last 0->1 transition.
//  4. i_Switch[1] high for 7 cycles, then low -> no output change on channel 1.
//     Then release channel 0 -> one o_Release[0] pulse, o_Toggle[0] holds 1.
//     Second press -> o_Toggle[0] returns to 0.
//  5. i_Rst_L=0 at cycle 5 of a PEND_HI -> outputs 0 asynchronously. Deassert
//     with raw still 1 -> o_Switch rises 10 edges later, single Press.
//  6. Macro undefined, repeat scenario 2 -> o_Switch/o_Press identical,
//     o_Toggle stays 2'b00.

Source files
------------

// File: rtl/switch_debounce_ctrl.sv
// Switch synchroniser and debouncer: clean levels, press/release pulses.
// SWITCH_DEBOUNCE_TOGGLE_EN builds the press-toggled level on o_Toggle.
module switch_debounce_ctrl #(
  parameter int NUM_SW         = 2,
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_SW-1:0] i_Switch,
  output logic [NUM_SW-1:0] o_Switch,
  output logic [NUM_SW-1:0] o_Press,
  output logic [NUM_SW-1:0] o_Release,
  output logic [NUM_SW-1:0] o_Toggle
);

  localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [1:0] {
    STABLE_LO,
    PEND_HI,
    STABLE_HI,
    PEND_LO
  } state_t;

  logic [NUM_SW-1:0] sync_q1;
  logic [NUM_SW-1:0] sync_q2;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= i_Switch;
      sync_q2 <= sync_q1;
    end
  end

  for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sw_q, sw_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          s;

    assign s = sync_q2[g];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sw_d    = sw_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      unique case (state_q)
        STABLE_LO: begin
          if (s) begin
            state_d = PEND_HI;
            cnt_d   = ONE;
          end
        end
        PEND_HI: begin
          if (!s) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == LIMIT) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
            sw_d    = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        STABLE_HI: begin
          if (!s) begin
            state_d = PEND_LO;
            cnt_d   = ONE;
          end
        end
        PEND_LO: begin
          if (s) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == LIMIT) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            sw_d    = 1'b0;
            rel_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        state_q <= STABLE_LO;
        cnt_q   <= '0;
        sw_q    <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        sw_q    <= sw_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    assign o_Switch[g]  = sw_q;
    assign o_Press[g]   = press_q;
    assign o_Release[g] = rel_q;

`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    logic tog_q;

    // flips on the same edge that raises o_Press
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        tog_q <= 1'b0;
      end else if (press_d) begin
        tog_q <= ~tog_q;
      end
    end

    assign o_Toggle[g] = tog_q;
`else
    assign o_Toggle[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// Bench for switch_debounce_ctrl: run-length model plus directed literals.
// Toggle expectations follow SWITCH_DEBOUNCE_TOGGLE_EN.
module tb_switch_debounce_ctrl;

  localparam int N = 2;
  localparam int L = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] sw = '0;
  logic [N-1:0] o_sw, o_pr, o_rl, o_tg;

  int n_checks = 0;
  int n_fail   = 0;
  int press_cnt = 0;

  switch_debounce_ctrl #(.NUM_SW(N), .DEBOUNCE_LIMIT(L)) dut (
    .i_Clk    (clk),
    .i_Rst_L  (rst_n),
    .i_Switch (sw),
    .o_Switch (o_sw),
    .o_Press  (o_pr),
    .o_Release(o_rl),
    .o_Toggle (o_tg)
  );

  always #20 clk = ~clk;

  // model: a level flips once L+1 consecutive samples oppose it,
  // where a sample is the raw input seen two edges earlier
  logic [N-1:0] d1, d2, m_sw, m_pr, m_rl, m_tg;
  int run [N];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        d1 = '0; d2 = '0; m_sw = '0;
        m_pr = '0; m_rl = '0; m_tg = '0;
        for (int i = 0; i < N; i++) run[i] = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          m_pr[i] = 1'b0;
          m_rl[i] = 1'b0;
          if (d2[i] != m_sw[i]) run[i]++;
          else run[i] = 0;
          if (run[i] == L + 1) begin
            run[i] = 0;
            m_sw[i] = d2[i];
            if (d2[i]) begin
              m_pr[i] = 1'b1;
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
              m_tg[i] = ~m_tg[i];
`endif
            end else begin
              m_rl[i] = 1'b1;
            end
          end
        end
        d2 = d1;
        d1 = sw;
      end
    end
  end

  task automatic chk(input string nm, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("model_sw", o_sw, m_sw);
      chk("model_press", o_pr, m_pr);
      chk("model_release", o_rl, m_rl);
      chk("model_toggle", o_tg, m_tg);
      if (o_pr[0]) press_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  localparam logic [N-1:0] TG1 = 2'b01;
  localparam logic [N-1:0] TG2 = 2'b10;
`else
  localparam logic [N-1:0] TG1 = 2'b00;
  localparam logic [N-1:0] TG2 = 2'b00;
`endif

  initial begin
    // reset held with switches pressed
    rst_n = 1'b0;
    sw = 2'b11;
    step(20);
    chk("rst_sw", o_sw, 2'b00);
    chk("rst_press", o_pr, 2'b00);
    chk("rst_tog", o_tg, 2'b00);
    sw = 2'b00;
    rst_n = 1'b1;
    step(5);

    // clean press on channel 0
    sw[0] = 1'b1;
    step(10);
    chk("press_early", o_sw, 2'b00);
    step(1);
    chk("press_sw", o_sw, 2'b01);
    chk("press_pulse", o_pr, 2'b01);
    chk("press_tog", o_tg, TG1);
    step(1);
    chk("press_once", o_pr, 2'b00);
    step(10);

    // short glitch on channel 1
    sw[1] = 1'b1;
    step(7);
    sw[1] = 1'b0;
    step(15);
    chk("glitch_sw", o_sw, 2'b01);

    // release channel 0
    sw[0] = 1'b0;
    step(10);
    chk("rel_early", o_rl, 2'b00);
    step(1);
    chk("rel_pulse", o_rl, 2'b01);
    chk("rel_sw", o_sw, 2'b00);
    chk("rel_tog", o_tg, TG1);
    step(10);

    // bouncy second press
    press_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      sw[0] = 1'b1;
      step(3);
      sw[0] = 1'b0;
      step(2);
    end
    sw[0] = 1'b1;
    step(10);
    chk("bounce_early", o_sw, 2'b00);
    step(1);
    chk("bounce_sw", o_sw, 2'b01);
    chk("bounce_pulse", o_pr, 2'b01);
    chk("bounce_tog", o_tg, 2'b00);
    step(20);
    chk_int("bounce_count", press_cnt, 1);

    // swap channels simultaneously, then reset mid-pend
    sw = 2'b10;
    step(15);
    chk("swap_sw", o_sw, 2'b10);
    chk("swap_tog", o_tg, TG2);
    sw = 2'b11;
    step(5);
    #5 rst_n = 1'b0;
    #1;
    chk("async_sw", o_sw, 2'b00);
    chk("async_tog", o_tg, 2'b00);
    step(3);
    rst_n = 1'b1;
    step(10);
    chk("rearm_early", o_sw, 2'b00);
    step(1);
    chk("rearm_sw", o_sw, 2'b11);
    chk("rearm_pulse", o_pr, 2'b11);
    step(1);
    chk("rearm_once", o_pr, 2'b00);
    step(20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
